seq_muldiv: RTL

//   Parametrised iterative multiply/divide unit for the MIPS datapath.

---
 rtl/seq_muldiv.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/seq_muldiv.sv
// Iterative MULTU/MULT/DIVU/DIV unit, one bit per cycle, results on hi/lo.
// Optional feature: define MULDIV_EARLY_OUT_EN to let multiplies leave CALC early.
module seq_muldiv #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] operand_a,
  input  logic [N-1:0] operand_b,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;
  localparam int CW = $clog2(N+1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            is_div_q, is_div_d;
  logic            neg_q_q, neg_q_d;   // sign of product / quotient
  logic            neg_r_q, neg_r_d;   // sign of remainder
  logic [N-1:0]    a_raw_q, a_raw_d;
  logic [N-1:0]    b_q, b_d;
  logic [2*N-1:0]  mc_q, mc_d;
  logic [2*N-1:0]  acc_q, acc_d;       // mul: product; div: {remainder, dividend/quotient}
  logic [N-1:0]    hi_q, hi_d, lo_q, lo_d;
  logic            dz_q, dz_d;

  logic            a_neg, b_neg, calc_end, ge;
  logic [N-1:0]    a_mag, b_mag, rem_new;
  logic [N:0]      r_sh;
  logic [2*N-1:0]  prod_fix;

`ifdef MULDIV_EARLY_OUT_EN
  // Multiplies stop once no multiplier bits remain to be consumed.
  assign calc_end = (cnt_q == CW'(N)) || (!is_div_q && (b_q == '0));
`else
  assign calc_end = (cnt_q == CW'(N));
`endif

  assign a_neg = op[0] & operand_a[N-1];
  assign b_neg = op[0] & operand_b[N-1];
  assign a_mag = a_neg ? (~operand_a + 1'b1) : operand_a;
  assign b_mag = b_neg ? (~operand_b + 1'b1) : operand_b;

  // Restoring step: shift next dividend bit into the partial remainder.
  assign r_sh    = {acc_q[2*N-1:N], acc_q[N-1]};
  assign ge      = (r_sh >= {1'b0, b_q});
  assign rem_new = ge ? (r_sh[N-1:0] - b_q) : r_sh[N-1:0];
  assign prod_fix = neg_q_q ? (~acc_q + 1'b1) : acc_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    a_raw_d  = a_raw_q;
    b_d      = b_q;
    mc_d     = mc_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dz_d     = dz_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d  = S_CALC;
          cnt_d    = '0;
          is_div_d = op[1];
          neg_q_d  = a_neg ^ b_neg;
          neg_r_d  = a_neg;
          a_raw_d  = operand_a;
          b_d      = b_mag;
          mc_d     = {{N{1'b0}}, a_mag};
          acc_d    = op[1] ? {{N{1'b0}}, a_mag} : '0;
          dz_d     = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        if (calc_end) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (is_div_q) begin
            acc_d = {rem_new, acc_q[N-2:0], ge};
          end else begin
            if (b_q[0]) acc_d = acc_q + mc_q;
            mc_d = mc_q << 1;
            b_d  = b_q >> 1;
          end
        end
      end
      S_FIX: begin
        state_d = S_DONE;
        if (!is_div_q) begin
          {hi_d, lo_d} = prod_fix;
        end else if (b_q == '0) begin
          dz_d = 1'b1;
          lo_d = '1;
          hi_d = a_raw_q;
        end else begin
          lo_d = neg_q_q ? (~acc_q[N-1:0] + 1'b1) : acc_q[N-1:0];
          hi_d = neg_r_q ? (~acc_q[2*N-1:N] + 1'b1) : acc_q[2*N-1:N];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      a_raw_q  <= '0;
      b_q      <= '0;
      mc_q     <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      a_raw_q  <= a_raw_d;
      b_q      <= b_d;
      mc_q     <= mc_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dz_q     <= dz_d;
    end
  end

  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dz_q;
  assign busy        = (state_q == S_CALC) || (state_q == S_FIX);
  assign done        = (state_q == S_DONE);

endmodule
